// File: rtl/demux_pkg.sv
// Shared constants and lane-offset helper for the registered 1-to-N demultiplexer.
package demux_pkg;

   localparam int DEMUX_DATA_W = 1;
   localparam int DEMUX_SEL_W  = 3;
   localparam int DEMUX_N_OUT  = 2 ** DEMUX_SEL_W;

   // Bit offset of lane k inside the packed output bus (lane 0 at the LSBs).
   function automatic int lane_lsb(input int k, input int data_w = DEMUX_DATA_W);
      return k * data_w;
   endfunction

endpackage

// File: rtl/demux_onehot_dec.sv
// Purely combinational SEL_W to 2**SEL_W one-hot decoder.
module demux_onehot_dec
   import demux_pkg::*;
#(
   parameter int SEL_W = DEMUX_SEL_W
) (
   input  logic [SEL_W-1:0]      sel_i,
   output logic [2**SEL_W-1:0]   onehot_o
);

   always_comb begin
      onehot_o        = '0;
      onehot_o[sel_i] = 1'b1;
   end

endmodule

// File: rtl/demux_eight_to_one.sv
// Registered 1-to-2**SEL_W demultiplexer: D00 is routed to lane s, all other lanes read zero.
module demux_eight_to_one
   import demux_pkg::*;
#(
   parameter int DATA_W = DEMUX_DATA_W,
   parameter int SEL_W  = DEMUX_SEL_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_W-1:0]              D00,
   input  logic [SEL_W-1:0]               s,
   output logic [(2**SEL_W)*DATA_W-1:0]   y
);

   localparam int N_OUT = 2 ** SEL_W;

   logic [N_OUT-1:0] lane_sel;

   demux_onehot_dec #(
      .SEL_W(SEL_W)
   ) u_dec (
      .sel_i   (s),
      .onehot_o(lane_sel)
   );

   // One register slice per lane; the select only gates data ahead of the flop.
   for (genvar k = 0; k < N_OUT; k++) begin : g_lane
      localparam int LSB = lane_lsb(k, DATA_W);

      logic [DATA_W-1:0] lane_d;
      logic [DATA_W-1:0] lane_q;

      assign lane_d = D00 & {DATA_W{lane_sel[k]}};

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            lane_q <= '0;
         end else begin
            lane_q <= lane_d;
         end
      end

      assign y[LSB +: DATA_W] = lane_q;
   end

endmodule

// File: tb/tb_demux_eight_to_one.sv
// Bench for demux_eight_to_one: default-width and 4-bit-wide instances share select and clock.
module tb_demux_eight_to_one;

   logic        clk;
   logic        rst;
   logic        d_n;
   logic [3:0]  d_w;
   logic [2:0]  s_in;
   logic [7:0]  y_n;
   logic [31:0] y_w;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_q[$];
   logic [31:0] exp_w_q[$];

   demux_eight_to_one u_dut_n (
      .clk(clk),
      .rst(rst),
      .D00(d_n),
      .s  (s_in),
      .y  (y_n)
   );

   demux_eight_to_one #(
      .DATA_W(4),
      .SEL_W (3)
   ) u_dut_w (
      .clk(clk),
      .rst(rst),
      .D00(d_w),
      .s  (s_in),
      .y  (y_w)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the data word shifted up to its lane position.
   function automatic logic [7:0] model_n(input logic d, input logic [2:0] sel);
      return 8'(d) << sel;
   endfunction

   function automatic logic [31:0] model_w(input logic [3:0] d, input logic [2:0] sel);
      return 32'(d) << (int'(sel) * 4);
   endfunction

   // Driver: apply inputs away from the edge, record the response due after the next edge.
   task automatic drive(input logic d, input logic [3:0] dw, input logic [2:0] sel);
      d_n  = d;
      d_w  = dw;
      s_in = sel;
      exp_q.push_back(model_n(d, sel));
      exp_w_q.push_back(model_w(dw, sel));
      @(posedge clk);
      #2;
   endtask

   // Monitor: output is presented every cycle, compared 1 time unit after the edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         check("narrow_y", 32'(y_n), 32'(exp_q.pop_front()));
         check("wide_y", y_w, exp_w_q.pop_front());
      end
   end

   initial begin
      int sweep[8] = '{0, 5, 3, 6, 0, 1, 6, 5};

      rst  = 1'b1;
      d_n  = 1'b1;
      d_w  = 4'hF;
      s_in = 3'd2;

      // reset state, held across an edge
      @(posedge clk);
      #2;
      check("reset_narrow", 32'(y_n), 32'h0);
      check("reset_wide", y_w, 32'h0);
      rst = 1'b0;
      #1;

      // select sweep with D00=1
      foreach (sweep[i]) drive(1'b1, 4'h5, 3'(sweep[i]));

      // zero data
      drive(1'b0, 4'h0, 3'd7);

      // select change between edges must not reach y
      drive(1'b1, 4'h3, 3'd2);
      s_in = 3'd5;
      #1;
      check("latency_narrow", 32'(y_n), 32'h04);
      check("latency_wide", y_w, 32'h0000_0300);
      drive(1'b1, 4'h3, 3'd5);

      // wide data on lane 3
      drive(1'b1, 4'hA, 3'd3);

      // reset during traffic: async clear, held across an edge, clean restart
      drive(1'b1, 4'h9, 3'd2);
      rst = 1'b1;
      #1;
      check("async_rst_narrow", 32'(y_n), 32'h0);
      check("async_rst_wide", y_w, 32'h0);
      @(posedge clk);
      #2;
      check("rst_hold_narrow", 32'(y_n), 32'h0);
      check("rst_hold_wide", y_w, 32'h0);
      rst = 1'b0;
      #1;
      drive(1'b1, 4'h9, 3'd2);

      // randomized traffic
      for (int i = 0; i < 200; i++) begin
         drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      end

      check("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
